stallable_pipeline_subtractor: RTL
==================================

# stallable_pipeline_subtractor

Four-stage pipelined WIDTH-bit subtractor computing `a - b - bin`, one WIDTH/4-bit slice per stage, with the borrow rippling between stage registers. It is the inverse-operation counterpart of the team's stallable pipelined adder and shares its per-stage `halt`/`flush` controls. Unlike the adder, every stage carries a valid bit and the block uses a valid/ready handshake on both ends, so stalls apply backpressure instead of propagating X/Z data. It sits in the datapath between an operand producer and a result consumer.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of 4; slice width S = WIDTH/4.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  stage 0 accepts this cycle (combinational).
- `a`, `b`  in  WIDTH  minuend and subtrahend.
- `bin`  in  1  borrow in.
- `halt`  in  4  per-stage hold; bit i applies to stage i.
- `flush`  in  4  per-stage invalidate; bit i applies to stage i.
- `out_valid`  out  1  result valid (stage 3 valid bit).
- `out_ready`  in  1  consumer accepts.
- `diff`  out  WIDTH  `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1  borrow out: 1 iff unsigned `a < b + bin`.
- `ovf`  out  1  signed overflow.

## Operation
- Stage i (0..3) computes slice bits `[S*(i+1)-1 : S*i]` as `a_slice + ~b_slice + ~borrow_prev`; carry-out inverted gives the next borrow. Stage 0 uses `bin`.
- Each stage register holds: valid bit, accumulated low diff bits, borrow, and the unconsumed upper slices of `a` and `b`.
- Define `adv[3] = out_ready | ~v[3]`, and for i < 3 `adv[i] = ~v[i] | ld[i+1]`.
- Stage i loads from its upstream source when `ld[i] = ~halt[i] & ~flush[i] & adv[i]`.
  - Upstream for stage 0 is the input port; `in_ready = ld[0]`.
  - On load, the new valid bit is the upstream valid. A halted upstream stage i-1 offers valid = 0, which inserts a bubble.
- When halt[i] is set, stage i holds its contents and offers nothing downstream. Upstream stages stall through `adv`.
- When flush[i] is set, v[i] is cleared at the edge and stage i does not load that cycle. Flush has priority over halt.
  - Flushing a valid stage drops exactly one operation.
  - The upstream stage holds its contents (it is not dropped).
- A transfer out occurs on `out_valid & out_ready`.
- `diff`, `bout` and `ovf` stay stable while `out_valid & ~out_ready`.
- Overflow rule: `ovf = (a[W-1] != b[W-1]) & (diff[W-1] != a[W-1])`.
  - This is independent of `bin`, except through `diff`.
- Results leave in acceptance order. No reordering, duplication or loss occurs except by flush.

## Timing
- Reset (the `rst` sampled high) clears all four valid bits to 0, and sets `diff` = 0, `bout` = 0, `ovf` = 0, `out_valid` = 0.
- With halt = 0, `in_ready` = 1 in the first cycle after reset deasserts.
- Reset asserted mid-stream discards all in-flight operations at that edge. `rst` overrides halt and flush.
- Latency: an operand set accepted at edge N gives `out_valid` = 1 after edge N+3 (4 register stages), provided no stalls occur.
- Throughput: one operation per cycle while `out_ready` = 1.
- Full pipeline with `out_ready` = 0: `in_ready` goes low in the same cycle, combinationally.
- `out_ready` rising again: the pipeline advances at the next edge and `in_ready` returns to 1 in that cycle.
- Each halted cycle at stage i adds one cycle of latency to every operation upstream of i.
- Simultaneous flush[i] and halt[i]: the flush takes effect.
- Simultaneous flush[i] and a valid stage i-1: stage i-1 holds for that cycle.

## Test plan
- **Reset:** hold `rst` = 1 for 2 cycles with `in_valid` = 1 → `out_valid` = 0, `diff` = 0, `bout` = 0, `ovf` = 0; `in_ready` = 1 in the first cycle after reset.
- **Streaming, back-to-back, `out_ready` = 1:** send 5-3, 0-1, 0x80000000-1, 0x01000000-1, and 7-7 with `bin` = 1. Require, 4 cycles after each input:
  - 5-3 → 0x00000002, `bout` 0, `ovf` 0.
  - 0-1 → 0xFFFFFFFF, `bout` 1, `ovf` 0.
  - 0x80000000-1 → 0x7FFFFFFF, `bout` 0, `ovf` 1.
  - 0x01000000-1 → 0x00FFFFFF; borrow ripples through all slices.
  - 7-7 with `bin` = 1 → 0xFFFFFFFF, `bout` 1.
- **Backpressure:** fill the pipeline, then drop `out_ready` for 3 cycles → `in_ready` = 0, `diff` held stable; on release, all results emerge in order with none lost or duplicated.
- **Halt:** continuous stream, `halt[1]` = 1 at cycles 10-11 → exactly 2 bubbles on the output; every input produces one correct result, in order.
- **Flush:** continuous stream, `flush[2]` pulse at cycle 15 → exactly one operation is missing from the output (the one in stage 2); its neighbours are correct.
- **Reset mid-stream:** `rst` pulse with 4 operations in flight → none of them appear; an operation accepted after reset returns correctly after 4 cycles.

Source files
------------

// File: rtl/stallable_pipeline_subtractor.sv
// stallable_pipeline_subtractor
//
// Four-stage pipelined subtractor computing (a - b - bin) mod 2^WIDTH. Each stage handles one
// WIDTH/4-bit slice, and the borrow ripples between the stage registers. Every stage has a valid
// bit. The block uses a valid/ready handshake on both ends, so stalls apply backpressure.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready operand handshake (in_ready is combinational)
//   a, b, bin         minuend, subtrahend, borrow in
//   halt[3:0]         per-stage hold
//   flush[3:0]        per-stage invalidate (has priority over halt)
//   out_valid/out_ready result handshake
//   diff, bout, ovf   difference, unsigned borrow out, signed overflow
//
// WIDTH must be a multiple of 4.
module stallable_pipeline_subtractor #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic [3:0]       halt,
    input  logic [3:0]       flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned S = WIDTH / 4;

    // Slice subtract as x + ~y + ~br. Returns {borrow_out, diff_slice}.
    function automatic logic [S:0] sub_slice(input logic [S-1:0] x, input logic [S-1:0] y,
                                             input logic br);
        logic [S:0] s;
        s = {1'b0, x} + {1'b0, ~y} + {{S{1'b0}}, ~br};
        return {~s[S], s[S-1:0]};
    endfunction

    // Stage registers. Each stage keeps the low diff bits produced so far, its borrow, and
    // only the operand slices that later stages still have to consume.
    logic [3:0]     v_q;
    logic [S-1:0]   d0_q;
    logic [2*S-1:0] d1_q;
    logic [3*S-1:0] d2_q;
    logic [WIDTH-1:0] d3_q;
    logic           br0_q, br1_q, br2_q, br3_q;
    logic [3*S-1:0] ah0_q, bh0_q;
    logic [2*S-1:0] ah1_q, bh1_q;
    logic [S-1:0]   ah2_q, bh2_q;
    logic           ovf3_q;

    logic ld0, ld1, ld2, ld3;
    logic of0, of1, of2, of3;
    logic [S:0] r0, r1, r2, r3;
    logic ovf3_d;

    // Load enables. The chain is written as separate scalars so there is no
    // self-dependent vector in the combinational logic.
    assign ld3 = ~halt[3] & ~flush[3] & (out_ready | ~v_q[3]);
    assign ld2 = ~halt[2] & ~flush[2] & (~v_q[2] | ld3);
    assign ld1 = ~halt[1] & ~flush[1] & (~v_q[1] | ld2);
    assign ld0 = ~halt[0] & ~flush[0] & (~v_q[0] | ld1);

    // Valid offered to each stage. A halted or flushed upstream stage offers a bubble.
    // A flushed stage must not also pass its operation on, or the operation would
    // not actually be dropped.
    assign of0 = in_valid;
    assign of1 = v_q[0] & ~halt[0] & ~flush[0];
    assign of2 = v_q[1] & ~halt[1] & ~flush[1];
    assign of3 = v_q[2] & ~halt[2] & ~flush[2];

    always_comb begin
        r0     = sub_slice(a[S-1:0], b[S-1:0], bin);
        r1     = sub_slice(ah0_q[S-1:0], bh0_q[S-1:0], br0_q);
        r2     = sub_slice(ah1_q[S-1:0], bh1_q[S-1:0], br1_q);
        r3     = sub_slice(ah2_q, bh2_q, br2_q);
        // The top slice of a and b carries the sign bits.
        ovf3_d = (ah2_q[S-1] ^ bh2_q[S-1]) & (r3[S-1] ^ ah2_q[S-1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            d0_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            d3_q   <= '0;
            br0_q  <= 1'b0;
            br1_q  <= 1'b0;
            br2_q  <= 1'b0;
            br3_q  <= 1'b0;
            ah0_q  <= '0;
            bh0_q  <= '0;
            ah1_q  <= '0;
            bh1_q  <= '0;
            ah2_q  <= '0;
            bh2_q  <= '0;
            ovf3_q <= 1'b0;
        end else begin
            // Stage 0
            if (flush[0]) begin
                v_q[0] <= 1'b0;
            end else if (ld0) begin
                v_q[0] <= of0;
                d0_q   <= r0[S-1:0];
                br0_q  <= r0[S];
                ah0_q  <= a[WIDTH-1:S];
                bh0_q  <= b[WIDTH-1:S];
            end
            // Stage 1
            if (flush[1]) begin
                v_q[1] <= 1'b0;
            end else if (ld1) begin
                v_q[1] <= of1;
                d1_q   <= {r1[S-1:0], d0_q};
                br1_q  <= r1[S];
                ah1_q  <= ah0_q[3*S-1:S];
                bh1_q  <= bh0_q[3*S-1:S];
            end
            // Stage 2
            if (flush[2]) begin
                v_q[2] <= 1'b0;
            end else if (ld2) begin
                v_q[2] <= of2;
                d2_q   <= {r2[S-1:0], d1_q};
                br2_q  <= r2[S];
                ah2_q  <= ah1_q[2*S-1:S];
                bh2_q  <= bh1_q[2*S-1:S];
            end
            // Stage 3
            if (flush[3]) begin
                v_q[3] <= 1'b0;
            end else if (ld3) begin
                v_q[3] <= of3;
                d3_q   <= {r3[S-1:0], d2_q};
                br3_q  <= r3[S];
                ovf3_q <= ovf3_d;
            end
        end
    end

    assign in_ready  = ld0;
    // A halted or flushed output stage offers nothing. This keeps the consumer from taking
    // a result that the stage then keeps or drops.
    assign out_valid = v_q[3] & ~halt[3] & ~flush[3];
    assign diff      = d3_q;
    assign bout      = br3_q;
    assign ovf       = ovf3_q;

endmodule
